// File: rtl/fruit_motion_pkg.sv
// Shared definitions for the fruit trajectory slice: state encoding, screen
// geometry, datapath widths and a small velocity helper.
package fruit_motion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLY    = 2'd1,
        ST_FALL   = 2'd2,
        ST_RETIRE = 2'd3
    } fruitState_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int VEL_W    = 8;
    localparam int POSX_W   = 10;
    localparam int POSY_W   = 9;

    // A sliced fruit may no longer travel upwards, so negative velocity is floored at zero.
    function automatic logic signed [VEL_W-1:0] clampUp(input logic signed [VEL_W-1:0] v);
        return (v < 0) ? '0 : v;
    endfunction

endpackage

// File: rtl/fruit_kinematics.sv
// Combinational per-frame motion step. Position wraps modulo the register
// width, and downward velocity gains gravity, then saturates.
module fruit_kinematics
    import fruit_motion_pkg::*;
#(
    parameter int GRAVITY = 1,
    parameter int VY_MAX  = 12
) (
    input  logic        [POSX_W-1:0] posx_i,
    input  logic        [POSY_W-1:0] posy_i,
    input  logic signed [VEL_W-1:0]  vx_i,
    input  logic signed [VEL_W-1:0]  vy_i,
    output logic        [POSX_W-1:0] posxNext_o,
    output logic        [POSY_W-1:0] posyNext_o,
    output logic signed [VEL_W-1:0]  vyNext_o
);

    localparam logic signed [VEL_W:0] GRAV9  = (VEL_W+1)'(GRAVITY);
    localparam logic signed [VEL_W:0] VYMAX9 = (VEL_W+1)'(VY_MAX);

    logic signed [VEL_W:0] vySum;

    // Next position/velocity. The velocity sum is one bit wider so +127 plus gravity cannot overflow before the clamp.
    always_comb begin
        posxNext_o = posx_i + {{(POSX_W-VEL_W){vx_i[VEL_W-1]}}, vx_i};
        posyNext_o = posy_i + {{(POSY_W-VEL_W){vy_i[VEL_W-1]}}, vy_i};
        vySum      = $signed({vy_i[VEL_W-1], vy_i}) + GRAV9;
        vyNext_o   = (vySum > VYMAX9) ? VYMAX9[VEL_W-1:0] : vySum[VEL_W-1:0];
    end

endmodule

// File: rtl/fruit_motion.sv
// Trajectory generator for one fruit slot: launch, per-frame ballistic update,
// arming against the out-of-bound flag, timeout and retire signalling.
// Optional feature macro: FRUIT_SLICE_EN enables slicing and the FALL state.
module fruit_motion
    import fruit_motion_pkg::*;
#(
    parameter int GRAVITY    = 1,
    parameter int VY_MAX     = 12,
    parameter int MAX_FRAMES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic                     launch,
    input  logic        [POSX_W-1:0] launch_x,
    input  logic        [POSY_W-1:0] launch_y,
    input  logic signed [VEL_W-1:0]  launch_vx,
    input  logic signed [VEL_W-1:0]  launch_vy,
    input  logic                     slice,
    input  logic                     oob,
    output logic        [POSX_W-1:0] posx,
    output logic        [POSY_W-1:0] posy,
    output logic                     active,
    output logic                     sliced,
    output logic                     retire,
    output logic                     missed
);

    localparam int CNT_W = $clog2(MAX_FRAMES + 1);

    fruitState_t              state_q, state_d;
    logic        [POSX_W-1:0] posx_q, posx_d;
    logic        [POSY_W-1:0] posy_q, posy_d;
    logic signed [VEL_W-1:0]  vx_q, vx_d;
    logic signed [VEL_W-1:0]  vy_q, vy_d;
    logic        [CNT_W-1:0]  frameCnt_q, frameCnt_d;
    logic                     armed_q, armed_d;
    logic                     sliced_q, sliced_d;
    logic                     missFlag_q, missFlag_d;
    logic                     tick1_q, tick1_d;
    logic                     tick2_q, tick2_d;

    logic                     sliceHit;
    logic signed [VEL_W-1:0]  vxEff, vyEff;
    logic        [POSX_W-1:0] posxNext;
    logic        [POSY_W-1:0] posyNext;
    logic signed [VEL_W-1:0]  vyNext;

`ifdef FRUIT_SLICE_EN
    assign sliceHit = (state_q == ST_FLY) && slice;
    assign sliced   = sliced_q;
`else
    logic unusedSlice;
    assign unusedSlice = slice;
    assign sliceHit    = 1'b0;
    assign sliced      = 1'b0;
`endif

    // A slice overrides velocity before any same-cycle frame update sees it.
    always_comb begin
        vxEff = vx_q;
        vyEff = vy_q;
        if (sliceHit) begin
            vxEff = '0;
            vyEff = clampUp(vy_q);
        end
    end

    fruit_kinematics #(
        .GRAVITY (GRAVITY),
        .VY_MAX  (VY_MAX)
    ) u_kinematics (
        .posx_i     (posx_q),
        .posy_i     (posy_q),
        .vx_i       (vxEff),
        .vy_i       (vyEff),
        .posxNext_o (posxNext),
        .posyNext_o (posyNext),
        .vyNext_o   (vyNext)
    );

    // Next-state logic: the oob sample lands two cycles after a tick, once the detector has registered the new position.
    always_comb begin
        state_d    = state_q;
        posx_d     = posx_q;
        posy_d     = posy_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        frameCnt_d = frameCnt_q;
        armed_d    = armed_q;
        sliced_d   = sliced_q;
        missFlag_d = missFlag_q;
        tick1_d    = 1'b0;
        tick2_d    = tick1_q;
        case (state_q)
            ST_IDLE: begin
                tick2_d = 1'b0;
                if (launch) begin
                    posx_d     = launch_x;
                    posy_d     = launch_y;
                    vx_d       = launch_vx;
                    vy_d       = launch_vy;
                    frameCnt_d = '0;
                    armed_d    = 1'b0;
                    sliced_d   = 1'b0;
                    missFlag_d = 1'b0;
                    state_d    = ST_FLY;
                end
            end
            ST_FLY, ST_FALL: begin
                tick1_d = frame_tick;
                if (sliceHit) begin
                    state_d  = ST_FALL;
                    sliced_d = 1'b1;
                    vx_d     = vxEff;
                    vy_d     = vyEff;
                end
                if (frame_tick) begin
                    posx_d     = posxNext;
                    posy_d     = posyNext;
                    vy_d       = vyNext;
                    frameCnt_d = frameCnt_q + 1'b1;
                end
                if (frameCnt_q == CNT_W'(MAX_FRAMES)) begin
                    state_d    = ST_RETIRE;
                    missFlag_d = 1'b0;
                end else if (tick2_q) begin
                    if (!oob) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d    = ST_RETIRE;
                        missFlag_d = ~(sliced_q | sliceHit);
                    end
                end
            end
            ST_RETIRE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            posx_q     <= '0;
            posy_q     <= '0;
            vx_q       <= '0;
            vy_q       <= '0;
            frameCnt_q <= '0;
            armed_q    <= 1'b0;
            sliced_q   <= 1'b0;
            missFlag_q <= 1'b0;
            tick1_q    <= 1'b0;
            tick2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            posx_q     <= posx_d;
            posy_q     <= posy_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            frameCnt_q <= frameCnt_d;
            armed_q    <= armed_d;
            sliced_q   <= sliced_d;
            missFlag_q <= missFlag_d;
            tick1_q    <= tick1_d;
            tick2_q    <= tick2_d;
        end
    end

    assign posx   = posx_q;
    assign posy   = posy_q;
    assign active = (state_q == ST_FLY) || (state_q == ST_FALL);
    assign retire = (state_q == ST_RETIRE);
    assign missed = (state_q == ST_RETIRE) && missFlag_q;

endmodule

// File: tb/tb_fruit_motion.sv
// Self-checking bench for fruit_motion. A behavioural model advances the fruit
// once per frame, using plain integer arithmetic. Honours FRUIT_SLICE_EN.
module tb_fruit_motion;

    localparam int GRAV  = 1;
    localparam int VYMAX = 12;
    localparam int MAXF  = 255;
`ifdef FRUIT_SLICE_EN
    localparam bit SLICE_EN = 1'b1;
`else
    localparam bit SLICE_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_tick;
    logic              launch;
    logic        [9:0] launch_x;
    logic        [8:0] launch_y;
    logic signed [7:0] launch_vx;
    logic signed [7:0] launch_vy;
    logic              slice;
    logic              oob;
    logic        [9:0] posx;
    logic        [8:0] posy;
    logic              active;
    logic              sliced;
    logic              retire;
    logic              missed;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit mActive, mSliced, mArmed, expRetire, expMiss;
    int mx, my, mvx, mvy, mCnt;

    fruit_motion #(
        .GRAVITY    (GRAV),
        .VY_MAX     (VYMAX),
        .MAX_FRAMES (MAXF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .launch     (launch),
        .launch_x   (launch_x),
        .launch_y   (launch_y),
        .launch_vx  (launch_vx),
        .launch_vy  (launch_vy),
        .slice      (slice),
        .oob        (oob),
        .posx       (posx),
        .posy       (posy),
        .active     (active),
        .sliced     (sliced),
        .retire     (retire),
        .missed     (missed)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point for every check.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkPosition(input string tag);
        checkOutput({tag, "_active"}, int'(active), int'(mActive));
        checkOutput({tag, "_posx"}, int'(posx), mx);
        checkOutput({tag, "_posy"}, int'(posy), my);
        checkOutput({tag, "_sliced"}, int'(sliced), int'(mSliced));
    endtask

    // Asynchronous reset: outputs must clear at once and no retire pulse may appear.
    task automatic applyReset();
        int pulses;
        pulses = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_active", int'(active), 0);
        checkOutput("rst_posx", int'(posx), 0);
        checkOutput("rst_posy", int'(posy), 0);
        checkOutput("rst_sliced", int'(sliced), 0);
        checkOutput("rst_missed", int'(missed), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (retire) pulses++;
        end
        rst = 1'b0;
        @(negedge clk);
        if (retire) pulses++;
        checkOutput("rst_no_retire", pulses, 0);
        mActive = 1'b0;
        mSliced = 1'b0;
        mx = 0;
        my = 0;
    endtask

    // Launch request; the model takes it only when the slot is idle.
    task automatic applyLaunch(input int x, input int y, input int vx, input int vy);
        @(negedge clk);
        launch    = 1'b1;
        launch_x  = 10'(x);
        launch_y  = 9'(y);
        launch_vx = 8'(vx);
        launch_vy = 8'(vy);
        @(negedge clk);
        launch = 1'b0;
        if (!mActive) begin
            mActive = 1'b1;
            mSliced = 1'b0;
            mArmed  = 1'b0;
            mCnt    = 0;
            mx = x;
            my = y;
            mvx = vx;
            mvy = vy;
        end
        checkPosition("launch");
    endtask

    // Slice pulse outside a frame tick.
    task automatic applySlice();
        @(negedge clk);
        slice = 1'b1;
        @(negedge clk);
        slice = 1'b0;
        if (SLICE_EN && mActive && !mSliced) begin
            mSliced = 1'b1;
            mvx = 0;
            if (mvy < 0) mvy = 0;
        end
        checkPosition("slice");
    endtask

    // One frame: tick (optionally with slice), oob held for the frame, then watch for retire.
    task automatic applyFrame(input bit oobVal, input bit sliceNow);
        int retires, missSeen, strayMiss;
        retires = 0;
        missSeen = 0;
        strayMiss = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        oob        = oobVal;
        slice      = sliceNow;
        if (sliceNow && SLICE_EN && !mSliced) begin
            mSliced = 1'b1;
            mvx = 0;
            if (mvy < 0) mvy = 0;
        end
        mx   = (((mx + mvx) % 1024) + 1024) % 1024;
        my   = (((my + mvy) % 512) + 512) % 512;
        mvy  = (mvy + GRAV > VYMAX) ? VYMAX : mvy + GRAV;
        mCnt = mCnt + 1;
        expRetire = 1'b0;
        expMiss   = 1'b0;
        if (mCnt == MAXF) begin
            expRetire = 1'b1;
        end else if (!oobVal) begin
            mArmed = 1'b1;
        end else if (mArmed) begin
            expRetire = 1'b1;
            expMiss   = !mSliced;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            slice      = 1'b0;
            if (retire) begin
                retires++;
                missSeen = int'(missed);
            end else if (missed) begin
                strayMiss++;
            end
        end
        checkOutput("frame_retire", retires, int'(expRetire));
        checkOutput("stray_missed", strayMiss, 0);
        if (expRetire) begin
            checkOutput("retire_missed", missSeen, int'(expMiss));
            checkOutput("retire_inactive", int'(active), 0);
            mActive = 1'b0;
        end else begin
            checkPosition("frame");
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed cases, then randomized flights.
    initial begin
        rst = 1'b1;
        frame_tick = 1'b0;
        launch = 1'b0;
        launch_x = '0;
        launch_y = '0;
        launch_vx = '0;
        launch_vy = '0;
        slice = 1'b0;
        oob = 1'b1;
        mActive = 1'b0;
        mSliced = 1'b0;
        mArmed = 1'b0;
        mx = 0;
        my = 0;
        mvx = 0;
        mvy = 0;
        mCnt = 0;
        applyReset();
        checkOutput("idle_retire", int'(retire), 0);

        // Three ticks under gravity with oob high: ends at (326,443), still flying.
        applyLaunch(320, 470, 2, -10);
        for (int i = 0; i < 3; i++) applyFrame(1'b1, 1'b0);
        checkOutput("plan_posx", int'(posx), 326);
        checkOutput("plan_posy", int'(posy), 443);
        // A second launch while flying is dropped.
        applyLaunch(5, 5, 1, 1);
        // Arm on a low sample, retire on the next high one as a miss.
        applyFrame(1'b0, 1'b0);
        applyFrame(1'b1, 1'b0);

        // Negative x velocity wraps modulo 1024, then reset mid-flight.
        applyLaunch(2, 200, -4, 0);
        applyFrame(1'b1, 1'b0);
        checkOutput("wrap_posx", int'(posx), 1022);
        applyReset();

        // Slice during flight, then arm and leave the screen.
        applyLaunch(100, 300, 3, -5);
        applyFrame(1'b1, 1'b0);
        applySlice();
        applyFrame(1'b1, 1'b0);
        applyFrame(1'b0, 1'b0);
        applyFrame(1'b1, 1'b0);

        // Downward velocity saturates.
        applyLaunch(300, 100, 0, 11);
        for (int i = 0; i < 3; i++) applyFrame(1'b1, 1'b0);
        checkOutput("sat_posy", int'(posy), 135);
        applyReset();

        // Lifetime limit with oob never low.
        applyLaunch(500, 470, 1, -10);
        for (int i = 0; i < MAXF && mActive; i++) applyFrame(1'b1, 1'b0);
        checkOutput("timeout_done", int'(mActive), 0);

        // Randomized flights with mixed oob, slices and stray launches.
        for (int f = 0; f < 8; f++) begin
            int n;
            applyLaunch(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                        int'($urandom_range(0, 12)) - 6, int'($urandom_range(0, 18)) - 20);
            n = 0;
            while (mActive && n < 25) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r == 0) applySlice();
                else if (r == 1) applyLaunch(int'($urandom_range(0, 1023)), 7, 3, -3);
                else applyFrame((n < 2) ? 1'b1 : 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
                n++;
            end
            if (mActive) applyReset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
